// File: rtl/sobol_seq_ctrl.sv
// sobol_seq_ctrl: request sequencer for one Sobol lane.
//
// A start from the batch scheduler launches a batch of cfg_n_paths paths by M
// dims. The block walks every (path, dim) pair and presents each one as an
// idx/dim request to the Sobol generator. It counts the points retired
// downstream, and pulses done once every issued request has retired.
//
// Handshake: a request transfers in any cycle where req_valid && req_ready.
// While req_valid is high and req_ready is low, req_idx, req_dim and req_last
// hold steady. req_valid never drops in RUN without a transfer, except through
// abort.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           one-cycle launch request, honoured only in IDLE
//   abort           stop issuing and drain, honoured only in RUN
//   cfg_n_paths     paths in the batch, sampled when start is accepted
//   cfg_path_major  1: dim is the inner loop; 0: path is the inner loop
//   req_valid/ready request handshake toward the Sobol generator
//   req_idx/dim     current request (idx = path count + IDX_OFFSET)
//   req_last        marks the final request of the batch
//   rsp_fire        one point retired downstream
//   busy            high in RUN and DRAIN
//   done            one-cycle pulse at batch completion
//   aborted         with done: batch ended by abort; held until next start
module sobol_seq_ctrl #(
  parameter int WIDTH      = 32,
  parameter int M          = 50,
  parameter int IDX_OFFSET = 1,
  localparam int DW        = (M > 1) ? $clog2(M) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] cfg_n_paths,
  input  logic             cfg_path_major,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [WIDTH-1:0] req_idx,
  output logic [DW-1:0]    req_dim,
  output logic             req_last,
  input  logic             rsp_fire,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  // One extra bit beyond WIDTH+DW, so that n*M can never wrap.
  localparam int CW = WIDTH + DW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] path_q, path_d;
  logic [DW-1:0]    dim_q, dim_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic             pm_q, pm_d;
  logic [CW-1:0]    issued_q, issued_d;
  logic [CW-1:0]    retired_q, retired_d;
  logic             aborted_q, aborted_d;

  logic fire;
  logic last_path;
  logic last_dim;
  logic last_pair;

  assign fire      = (state_q == RUN) && req_ready;
  assign last_path = (path_q == n_q - WIDTH'(1));
  assign last_dim  = (dim_q == DW'(M - 1));
  assign last_pair = last_path && last_dim;

  always_comb begin
    state_d   = state_q;
    path_d    = path_q;
    dim_d     = dim_q;
    n_d       = n_q;
    pm_d      = pm_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    aborted_d = aborted_q;

    if (rsp_fire && (state_q == RUN || state_q == DRAIN))
      retired_d = retired_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          n_d       = cfg_n_paths;
          pm_d      = cfg_path_major;
          path_d    = '0;
          dim_d     = '0;
          issued_d  = '0;
          retired_d = '0;
          aborted_d = 1'b0;
          // An empty batch completes without issuing anything.
          state_d   = (cfg_n_paths != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (fire) begin
          issued_d = issued_q + CW'(1);
          // On the last pair the counters stay put; nothing is presented after it.
          if (!last_pair) begin
            if (pm_q) begin
              if (last_dim) begin
                dim_d  = '0;
                path_d = path_q + WIDTH'(1);
              end else begin
                dim_d = dim_q + DW'(1);
              end
            end else begin
              if (last_path) begin
                path_d = '0;
                dim_d  = dim_q + DW'(1);
              end else begin
                path_d = path_q + WIDTH'(1);
              end
            end
          end
        end
        if (fire && last_pair) state_d = DRAIN;
        if (abort) begin
          state_d   = DRAIN;
          aborted_d = 1'b1;
        end
      end
      DRAIN: begin
        // Look at the updated retire count, so that done follows the final
        // retirement by one cycle.
        if (retired_d == issued_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      path_q    <= '0;
      dim_q     <= '0;
      n_q       <= '0;
      pm_q      <= 1'b0;
      issued_q  <= '0;
      retired_q <= '0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      path_q    <= path_d;
      dim_q     <= dim_d;
      n_q       <= n_d;
      pm_q      <= pm_d;
      issued_q  <= issued_d;
      retired_q <= retired_d;
      aborted_q <= aborted_d;
    end
  end

  assign req_valid = (state_q == RUN);
  assign req_idx   = path_q + WIDTH'(IDX_OFFSET);
  assign req_dim   = dim_q;
  assign req_last  = req_valid && last_pair;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign aborted   = aborted_q;

  // Downstream can never retire more points than were issued to it.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (retired_q <= issued_q)
        else $error("sobol_seq_ctrl: retired %0d exceeds issued %0d", retired_q, issued_q);
    end
  end

endmodule

// File: tb/tb_sobol_seq_ctrl.sv
// Testbench for sobol_seq_ctrl. It uses a small lane (M=3, WIDTH=16).
module tb_sobol_seq_ctrl;

  localparam int WIDTH      = 16;
  localparam int M          = 3;
  localparam int IDX_OFFSET = 1;
  localparam int DW         = 2;
  localparam int PW         = WIDTH + DW;
  localparam int LIMIT      = 400;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] cfg_n_paths;
  logic             cfg_path_major;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_idx;
  logic [DW-1:0]    req_dim;
  logic             req_last;
  logic             rsp_fire;
  logic             busy;
  logic             done;
  logic             aborted;

  int vectors     = 0;
  int miscompares = 0;

  // Expected (idx, dim) pairs still to be requested, in order.
  logic [PW-1:0] exp_q[$];

  sobol_seq_ctrl #(.WIDTH(WIDTH), .M(M), .IDX_OFFSET(IDX_OFFSET)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .cfg_n_paths    (cfg_n_paths),
    .cfg_path_major (cfg_path_major),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_idx        (req_idx),
    .req_dim        (req_dim),
    .req_last       (req_last),
    .rsp_fire       (rsp_fire),
    .busy           (busy),
    .done           (done),
    .aborted        (aborted)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard compare ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  // Reference order: the set of all pairs, listed according to the loop nesting.
  task automatic build_expected(input int n, input bit pm);
    exp_q.delete();
    if (pm) begin
      for (int p = 0; p < n; p++)
        for (int d = 0; d < M; d++)
          exp_q.push_back({WIDTH'(p + IDX_OFFSET), DW'(d)});
    end else begin
      for (int d = 0; d < M; d++)
        for (int p = 0; p < n; p++)
          exp_q.push_back({WIDTH'(p + IDX_OFFSET), DW'(d)});
    end
  endtask

  // ---------------- driver: one full batch ----------------
  // Each task is entered and left 1 time unit after a rising edge.
  // ready_mode: 0 random, 1 always ready, 2 stall 4 cycles on the 2nd request.
  // lag: outstanding points kept un-retired while requests are still issuing.
  task automatic run_batch(input int n, input bit pm, input int abort_at,
                           input int lag, input int ready_mode);
    int issued = 0;
    int outst  = 0;
    int stall  = 0;
    int cyc    = 0;
    bit ending = 0;
    bit aborted_m = 0;
    bit in_drain;
    bit exp_valid;
    bit got_done = 0;

    build_expected(n, pm);
    cfg_n_paths    = WIDTH'(n);
    cfg_path_major = pm;
    start          = 1'b1;
    rsp_fire       = 1'b1;  // stray retire while idle must be ignored
    @(posedge clk); #1;
    start          = 1'b0;
    rsp_fire       = 1'b0;
    cfg_n_paths    = WIDTH'($urandom);
    cfg_path_major = 1'($urandom);
    check("start_aborted_clear", {63'd0, aborted}, 64'd0);

    if (n == 0) begin
      check("empty_done",  {63'd0, done},      64'd1);
      check("empty_valid", {63'd0, req_valid}, 64'd0);
      check("empty_busy",  {63'd0, busy},      64'd0);
      @(posedge clk); #1;
      check("empty_idle_done", {63'd0, done}, 64'd0);
      check("empty_idle_busy", {63'd0, busy}, 64'd0);
      return;
    end

    while (!got_done && cyc < LIMIT) begin
      exp_valid = !ending;
      check("req_valid", {63'd0, req_valid}, {63'd0, exp_valid});
      check("busy",      {63'd0, busy},      64'd1);
      check("done_low",  {63'd0, done},      64'd0);
      if (exp_valid && exp_q.size() > 0) begin
        check("req_pair", {46'd0, req_idx, req_dim}, {46'd0, exp_q[0]});
        check("req_last", {63'd0, req_last}, {63'd0, exp_q.size() == 1});
      end

      if (ready_mode == 2 && issued == 1 && stall < 4) begin
        req_ready = 1'b0;
        stall++;
      end else if (ready_mode == 1 || ready_mode == 2) begin
        req_ready = 1'b1;
      end else begin
        req_ready = ($urandom_range(0, 3) != 0);
      end
      rsp_fire       = (outst > (ending ? 0 : lag)) && ($urandom_range(0, 1) == 1);
      abort          = !ending && abort_at >= 0 && issued == abort_at;
      start          = ($urandom_range(0, 7) == 0);  // must be ignored while busy
      cfg_n_paths    = WIDTH'($urandom);
      cfg_path_major = 1'($urandom);
      in_drain       = ending;

      @(posedge clk); #1;
      if (rsp_fire) outst--;
      if (exp_valid && req_ready) begin
        void'(exp_q.pop_front());
        issued++;
        outst++;
        if (exp_q.size() == 0) ending = 1;
      end
      if (abort) begin
        ending    = 1;
        aborted_m = 1;
      end
      abort    = 1'b0;
      rsp_fire = 1'b0;
      start    = 1'b0;

      // Completion comes one cycle after a draining cycle that retired the final point.
      if (in_drain && outst == 0) begin
        got_done = 1;
        check("done_pulse",    {63'd0, done},      64'd1);
        check("done_aborted",  {63'd0, aborted},   {63'd0, aborted_m});
        check("done_valid",    {63'd0, req_valid}, 64'd0);
      end
      cyc++;
    end
    check("batch_completed", {63'd0, got_done}, 64'd1);
    if (!aborted_m) check("all_pairs_issued", 64'(exp_q.size()), 64'd0);

    // A start in the DONE cycle is ignored; aborted holds into IDLE.
    start       = 1'b1;
    cfg_n_paths = WIDTH'(2);
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_busy",    {63'd0, busy},      64'd0);
    check("idle_valid",   {63'd0, req_valid}, 64'd0);
    check("idle_done",    {63'd0, done},      64'd0);
    check("idle_aborted", {63'd0, aborted},   {63'd0, aborted_m});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   {63'd0, req_valid}, 64'd0);
    check({tag, "_last"},    {63'd0, req_last},  64'd0);
    check({tag, "_busy"},    {63'd0, busy},      64'd0);
    check({tag, "_done"},    {63'd0, done},      64'd0);
    check({tag, "_aborted"}, {63'd0, aborted},   64'd0);
    check({tag, "_idx"},     {48'd0, req_idx},   64'(IDX_OFFSET));
    check({tag, "_dim"},     {62'd0, req_dim},   64'd0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    abort          = 1'b0;
    cfg_n_paths    = '0;
    cfg_path_major = 1'b0;
    req_ready      = 1'b0;
    rsp_fire       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_batch(2, 1'b1, -1, 0, 1);   // path-major, always ready
    run_batch(2, 1'b0, -1, 0, 1);   // dim-major, always ready
    run_batch(2, 1'b1, -1, 0, 2);   // 4-cycle stall on the 2nd request
    run_batch(0, 1'b1, -1, 0, 1);   // empty batch
    run_batch(4, 1'b1, 10, 2, 1);   // abort after 10 fires, 2 still outstanding

    // Reset in the middle of a batch, then a fresh full batch.
    cfg_n_paths    = WIDTH'(3);
    cfg_path_major = 1'b1;
    start          = 1'b1;
    req_ready      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #2;
    check_reset_outputs("async_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_batch(3, 1'b1, -1, 0, 0);

    // Randomized batches.
    for (int b = 0; b < 10; b++) begin
      int n_r;
      int ab;
      n_r = $urandom_range(1, 5);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(0, n_r * M - 1) : -1;
      run_batch(n_r, 1'($urandom), ab, $urandom_range(0, 2), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
